lab2_cmd_parser: RTL

- Upstream stage of the Lab2 adder.
- Consumes UART receive bytes and parses ASCII command lines of the form `<hex r1><op><hex r2><CR>`.
- On CR it presents registered r1, r2, cin and subtract flag to the adder, with a widened data-ready strobe.
- Separately decodes debug control characters into a ctrl byte plus a ctrl-signal level for the adder's debug LED mux.

---
 rtl/lab2_cmd_parser_if.sv | 10 +
 rtl/lab2_cmd_parser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_cmd_parser_if.sv
// rtl/lab2_cmd_parser_if.sv - UART byte stream in (rx) and echo stream out (tx) for lab2_cmd_parser
interface lab2_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (output rx_data, rx_valid, input  tx_data, tx_valid);
    modport slave  (input  rx_data, rx_valid, output tx_data, tx_valid);
endinterface

// File: rtl/lab2_cmd_parser.sv
// rtl/lab2_cmd_parser.sv - ASCII "<hex><op><hex><CR>" parser feeding the Lab2 adder; echo under LAB2_CMD_PARSER_ECHO_EN
module lab2_cmd_parser #(
    parameter int RDY_CYCLES = 2,
    parameter int MAX_DIGITS = 2
) (
    input  logic             i_clk_in,
    input  logic             i_rst_n,
    lab2_cmd_parser_if.slave uart,
    output logic [7:0]       o_r1,
    output logic [7:0]       o_r2,
    output logic             o_cin,
    output logic             o_substrate_signal,
    output logic             o_data_rdy,
    output logic [7:0]       o_ctrl,
    output logic             o_ctrl_signal,
    output logic             o_err
);
    typedef enum logic [1:0] {S_R1, S_R2, S_ERR} state_t;

    localparam int         KEEP_BITS = (MAX_DIGITS >= 2) ? 8 : 4 * MAX_DIGITS;
    localparam logic [7:0] ACC_MASK  = 8'((16'd1 << KEEP_BITS) - 16'd1);
    localparam logic [3:0] RDY_LOAD  = 4'(RDY_CYCLES);

    state_t     r_state, w_state;
    logic [7:0] r_acc1, w_acc1, r_acc2, w_acc2;
    logic       r_has1, w_has1, r_has2, w_has2;
    logic       r_op_sub, w_op_sub, r_op_cin, w_op_cin;
    logic [7:0] r_r1, w_r1, r_r2, w_r2;
    logic       r_cin, w_cin, r_sub, w_sub;
    logic [3:0] r_rdy_cnt, w_rdy_cnt;
    logic       r_rdy_gap, w_rdy_gap;
    logic [7:0] r_ctrl, w_ctrl;
    logic       r_ctrl_sig, w_ctrl_sig;
    logic       r_err, w_err;
    logic       w_emit, w_clear;

    logic [7:0] w_b;
    logic       w_is_dig, w_is_hex, w_is_op, w_is_cr, w_is_sp, w_is_ctrl;
    logic [3:0] w_nib;

    assign w_b       = uart.rx_data;
    assign w_is_dig  = (w_b >= 8'h30) && (w_b <= 8'h39);
    assign w_is_hex  = w_is_dig || ((w_b >= 8'h41) && (w_b <= 8'h46)) || ((w_b >= 8'h61) && (w_b <= 8'h66));
    assign w_is_op   = (w_b == 8'h2B) || (w_b == 8'h2D) || (w_b == 8'h23);
    assign w_is_cr   = (w_b == 8'h0D);
    assign w_is_sp   = (w_b == 8'h20);
    assign w_is_ctrl = (w_b >= 8'h7A) && (w_b <= 8'h7F);
    // Letters A-F and a-f share low nibbles 1..6, so +9 maps both cases to 10..15.
    assign w_nib     = w_is_dig ? w_b[3:0] : w_b[3:0] + 4'd9;

    always_comb begin
        w_state    = r_state;
        w_acc1     = r_acc1;
        w_acc2     = r_acc2;
        w_has1     = r_has1;
        w_has2     = r_has2;
        w_op_sub   = r_op_sub;
        w_op_cin   = r_op_cin;
        w_ctrl     = r_ctrl;
        w_ctrl_sig = r_ctrl_sig;
        w_err      = 1'b0;
        w_emit     = 1'b0;
        w_clear    = 1'b0;
        if (uart.rx_valid) begin
            if (w_is_ctrl) begin
                w_ctrl     = w_b;
                w_ctrl_sig = 1'b1;
            end else begin
                if (w_is_hex || w_is_op) w_ctrl_sig = 1'b0;
                if (w_is_cr && r_ctrl_sig) w_ctrl = 8'h0D;
                case (r_state)
                    S_R1: begin
                        if (w_is_hex) begin
                            w_acc1 = {r_acc1[3:0], w_nib} & ACC_MASK;
                            w_has1 = 1'b1;
                        end else if (w_is_op) begin
                            if (r_has1) begin
                                w_op_sub = (w_b == 8'h2D);
                                w_op_cin = (w_b == 8'h23);
                                w_state  = S_R2;
                            end else begin
                                w_err = 1'b1;
                            end
                        end else if (w_is_cr) begin
                            w_err = r_has1;
                        end else if (!w_is_sp) begin
                            w_err = 1'b1;
                        end
                    end
                    S_R2: begin
                        if (w_is_hex) begin
                            w_acc2 = {r_acc2[3:0], w_nib} & ACC_MASK;
                            w_has2 = 1'b1;
                        end else if (w_is_cr && r_has2) begin
                            w_emit = 1'b1;
                        end else if (!w_is_sp) begin
                            w_err = 1'b1;
                        end
                    end
                    default: begin
                        if (w_is_cr) begin
                            w_state = S_R1;
                            w_clear = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (w_err) w_state = S_ERR;
        if (w_emit) begin
            w_state = S_R1;
            w_clear = 1'b1;
        end
        if (w_clear) begin
            w_acc1   = 8'h00;
            w_acc2   = 8'h00;
            w_has1   = 1'b0;
            w_has2   = 1'b0;
            w_op_sub = 1'b0;
            w_op_cin = 1'b0;
        end
    end

    always_comb begin
        w_r1      = w_emit ? r_acc1   : r_r1;
        w_r2      = w_emit ? r_acc2   : r_r2;
        w_cin     = w_emit ? r_op_cin : r_cin;
        w_sub     = w_emit ? r_op_sub : r_sub;
        w_rdy_cnt = r_rdy_cnt;
        w_rdy_gap = 1'b0;
        // A re-emit during a live pulse drops rdy for one cycle so downstream sees a new rising edge.
        if (w_emit) begin
            if (r_rdy_cnt != 4'd0) w_rdy_gap = 1'b1;
            w_rdy_cnt = (r_rdy_cnt != 4'd0) ? 4'd0 : RDY_LOAD;
        end else if (r_rdy_gap) begin
            w_rdy_cnt = RDY_LOAD;
        end else if (r_rdy_cnt != 4'd0) begin
            w_rdy_cnt = r_rdy_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_R1;
            r_acc1     <= 8'h00;
            r_acc2     <= 8'h00;
            r_has1     <= 1'b0;
            r_has2     <= 1'b0;
            r_op_sub   <= 1'b0;
            r_op_cin   <= 1'b0;
            r_r1       <= 8'h00;
            r_r2       <= 8'h00;
            r_cin      <= 1'b0;
            r_sub      <= 1'b0;
            r_rdy_cnt  <= 4'd0;
            r_rdy_gap  <= 1'b0;
            r_ctrl     <= 8'h00;
            r_ctrl_sig <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_acc1     <= w_acc1;
            r_acc2     <= w_acc2;
            r_has1     <= w_has1;
            r_has2     <= w_has2;
            r_op_sub   <= w_op_sub;
            r_op_cin   <= w_op_cin;
            r_r1       <= w_r1;
            r_r2       <= w_r2;
            r_cin      <= w_cin;
            r_sub      <= w_sub;
            r_rdy_cnt  <= w_rdy_cnt;
            r_rdy_gap  <= w_rdy_gap;
            r_ctrl     <= w_ctrl;
            r_ctrl_sig <= w_ctrl_sig;
            r_err      <= w_err;
        end
    end

    assign o_r1               = r_r1;
    assign o_r2               = r_r2;
    assign o_cin              = r_cin;
    assign o_substrate_signal = r_sub;
    assign o_data_rdy         = (r_rdy_cnt != 4'd0);
    assign o_ctrl             = r_ctrl;
    assign o_ctrl_signal      = r_ctrl_sig;
    assign o_err              = r_err;

`ifdef LAB2_CMD_PARSER_ECHO_EN
    logic [7:0] r_tx_data, r_skid, w_echo_b;
    logic       r_tx_valid, r_skid_v, r_lf_pend, w_echo_v;

    always_comb begin
        w_echo_v = 1'b0;
        w_echo_b = w_b;
        if (uart.rx_valid) begin
            if (w_err) begin
                w_echo_v = 1'b1;
                w_echo_b = 8'h3F;
            end else if (w_is_ctrl) begin
                w_echo_v = 1'b1;
            end else if (r_state == S_ERR) begin
                w_echo_v = w_is_cr;
            end else begin
                w_echo_v = w_is_hex || w_is_op || w_is_cr || w_is_sp;
            end
        end
    end

    // LF after CR takes the slot of any byte arriving right behind the CR; that byte waits one cycle in r_skid.
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_skid     <= 8'h00;
            r_skid_v   <= 1'b0;
            r_lf_pend  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            if (r_lf_pend) begin
                r_tx_data  <= 8'h0A;
                r_tx_valid <= 1'b1;
                r_lf_pend  <= 1'b0;
                if (w_echo_v) begin
                    r_skid   <= w_echo_b;
                    r_skid_v <= 1'b1;
                end
            end else if (r_skid_v) begin
                r_tx_data  <= r_skid;
                r_tx_valid <= 1'b1;
                r_lf_pend  <= (r_skid == 8'h0D);
                if (w_echo_v) r_skid <= w_echo_b;
                else          r_skid_v <= 1'b0;
            end else if (w_echo_v) begin
                r_tx_data  <= w_echo_b;
                r_tx_valid <= 1'b1;
                r_lf_pend  <= (w_echo_b == 8'h0D);
            end
        end
    end

    assign uart.tx_data  = r_tx_data;
    assign uart.tx_valid = r_tx_valid;
`else
    assign uart.tx_data  = 8'h00;
    assign uart.tx_valid = 1'b0;
`endif
endmodule
